// File: rtl/divider_taint_track.sv
// Sequential restoring divider (one quotient bit per cycle) with a taint shadow on every
// data and control signal, so information-flow checks can follow quotient and remainder.
module divider_taint_track #(
  parameter int WIDTH = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] dividend_t,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0] divisor_t,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] quotient_t,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] remainder_t,
  output logic             busy,
  output logic             busy_t,
  output logic             quotientDone,
  output logic             quotientDone_t,
  output logic             divByZero,
  output logic             divByZero_t
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_st;
  logic [WIDTH-1:0] r_dq, r_dq_t, r_dv, r_dv_t;
  // The partial remainder is always below the divisor, so its extra top bit is
  // never set and is not stored.
  logic [WIDTH-1:0] r_rem, r_rem_t;
  logic             r_done;

  logic [WIDTH:0]   w_r;
  logic             w_took;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_rt, w_mix, w_sub_t, w_rem_t_nx;
  logic             w_cmp_t;

  assign w_r    = {r_rem, r_dq[WIDTH-1]};
  assign w_took = (w_r >= {1'b0, r_dv});
  assign w_diff = w_r[WIDTH-1:0] - r_dv;

  assign w_rt    = {r_rem_t[WIDTH-2:0], r_dq_t[WIDTH-1]};
  assign w_cmp_t = (|r_rem_t) | r_dq_t[WIDTH-1] | (|r_dv_t);
  assign w_mix   = w_rt | r_dv_t;

  // Borrow ripples upward: a tainted bit taints every more-significant difference bit.
  always_comb begin : p_smear
    logic acc;
    acc     = 1'b0;
    w_sub_t = '0;
    for (int i = 0; i < WIDTH; i++) begin
      acc        = acc | w_mix[i];
      w_sub_t[i] = acc;
    end
  end

  always_comb begin
    w_rem_t_nx = w_rt;
    if (w_cmp_t)     w_rem_t_nx = w_rt | w_sub_t;
    else if (w_took) w_rem_t_nx = w_sub_t;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = LOAD;
      LOAD:    w_next = CALC;
      CALC:    if (r_cnt == CW'(WIDTH - 1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy           = (r_state != IDLE);
    busy_t         = r_st;
    quotientDone   = r_done;
    quotientDone_t = r_st;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_st        <= 1'b0;
      r_dq        <= '0;
      r_dq_t      <= '0;
      r_dv        <= '0;
      r_dv_t      <= '0;
      r_rem       <= '0;
      r_rem_t     <= '0;
      r_done      <= 1'b0;
      quotient    <= '0;
      quotient_t  <= '0;
      remainder   <= '0;
      remainder_t <= '0;
      divByZero   <= 1'b0;
      divByZero_t <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      // A tainted start line leaks timing of every later operation, so it sticks.
      if (r_state == IDLE && start_t) r_st <= 1'b1;
      case (r_state)
        LOAD: begin
          r_dq    <= dividend;
          r_dq_t  <= dividend_t;
          r_dv    <= divisor;
          r_dv_t  <= divisor_t;
          r_rem   <= '0;
          r_rem_t <= '0;
          r_cnt   <= '0;
        end
        CALC: begin
          r_cnt   <= r_cnt + CW'(1);
          r_rem   <= w_took ? w_diff : w_r[WIDTH-1:0];
          r_dq    <= {r_dq[WIDTH-2:0], w_took};
          r_rem_t <= w_rem_t_nx;
          r_dq_t  <= {r_dq_t[WIDTH-2:0], w_cmp_t};
        end
        DONE: begin
          quotient    <= r_dq;
          remainder   <= r_rem;
          quotient_t  <= r_st ? '1 : r_dq_t;
          remainder_t <= r_st ? '1 : r_rem_t;
          divByZero   <= ~|r_dv;
          divByZero_t <= r_st | (|r_dv_t);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_taint_track.sv
// Directed bench for divider_taint_track at WIDTH=8 with a behavioural model of results,
// taint and timing, checked every cycle, plus hand-computed literal pins.
module tb_divider_taint_track;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, start_t = 1'b0;
  logic [W-1:0] dividend = '0, dividend_t = '0, divisor = '0, divisor_t = '0;
  logic [W-1:0] quotient, quotient_t, remainder, remainder_t;
  logic busy, busy_t, quotientDone, quotientDone_t, divByZero, divByZero_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int t0 = 0;
  bit active = 0;
  bit m_st = 0;
  logic [W-1:0] e_q, e_r, e_qt, e_rt;
  logic e_dz, e_dzt;

  divider_taint_track #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .start_t(start_t),
    .dividend(dividend), .dividend_t(dividend_t), .divisor(divisor), .divisor_t(divisor_t),
    .quotient(quotient), .quotient_t(quotient_t), .remainder(remainder), .remainder_t(remainder_t),
    .busy(busy), .busy_t(busy_t), .quotientDone(quotientDone), .quotientDone_t(quotientDone_t),
    .divByZero(divByZero), .divByZero_t(divByZero_t)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Results from plain division; taint from the propagation rules, step by step, where a
  // step subtracts exactly when its quotient bit is one.
  function automatic void model(input logic [W-1:0] a, b, at, bt, input bit st,
                                output logic [W-1:0] q, r, qt, rt, output logic dz, dzt);
    logic [W:0] remt, rv, mix, subt;
    logic [W-1:0] dqt;
    logic cmpt, acc, took;
    if (b == 0) begin q = '1; r = a; end
    else begin q = a / b; r = a % b; end
    remt = '0;
    dqt  = at;
    for (int s = 0; s < W; s++) begin
      rv   = {remt[W-1:0], dqt[W-1]};
      cmpt = (|rv) | (|bt);
      mix  = rv | {1'b0, bt};
      acc  = 1'b0;
      for (int i = 0; i <= W; i++) begin acc = acc | mix[i]; subt[i] = acc; end
      took = q[W-1-s];
      if (cmpt)      remt = rv | subt;
      else if (took) remt = subt;
      else           remt = rv;
      dqt = {dqt[W-2:0], cmpt};
    end
    dz = (b == 0);
    if (st) begin qt = '1; rt = '1; dzt = 1'b1; end
    else begin qt = dqt; rt = remt[W-1:0]; dzt = |bt; end
  endfunction

  always @(negedge clk) begin : mon
    int k;
    if (!rst) begin
      check("rst_busy", busy, 0);
      check("rst_busy_t", busy_t, 0);
      check("rst_done", quotientDone, 0);
      check("rst_done_t", quotientDone_t, 0);
      check("rst_q", quotient, 0);
      check("rst_r", remainder, 0);
      check("rst_qt", quotient_t, 0);
      check("rst_rt", remainder_t, 0);
      check("rst_dz", divByZero, 0);
      check("rst_dzt", divByZero_t, 0);
    end else begin
      k = cyc - t0;
      check("busy", busy, (active && k <= W + 1) ? 1 : 0);
      check("busy_t", busy_t, m_st);
      check("done", quotientDone, (active && k == W + 2) ? 1 : 0);
      check("done_t", quotientDone_t, m_st);
      if (active && k == W + 2) begin
        check("q", quotient, e_q);
        check("r", remainder, e_r);
        check("qt", quotient_t, e_qt);
        check("rt", remainder_t, e_rt);
        check("dz", divByZero, e_dz);
        check("dzt", divByZero_t, e_dzt);
      end
    end
  end

  task automatic begin_op(input logic [W-1:0] a, b, at, bt, input bit st);
    @(negedge clk);
    dividend = a; divisor = b; dividend_t = at; divisor_t = bt;
    start = 1'b1; start_t = st;
    @(posedge clk); #1;
    start = 1'b0; start_t = 1'b0;
    if (st) m_st = 1'b1;
    model(a, b, at, bt, m_st, e_q, e_r, e_qt, e_rt, e_dz, e_dzt);
    t0 = cyc;
    active = 1'b1;
  endtask

  // poke drives start/start_t mid-calculation, which must have no effect.
  task automatic do_op(input logic [W-1:0] a, b, at, bt, input bit st, input bit poke);
    bit got;
    begin_op(a, b, at, bt, st);
    got = 0;
    for (int i = 0; i < W + 8 && !got; i++) begin
      @(negedge clk);
      if (poke && i == 3) begin start = 1'b1; start_t = 1'b1; end
      if (poke && i == 5) begin start = 1'b0; start_t = 1'b0; end
      if (quotientDone) got = 1;
    end
    check("done_timeout", got, 1);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b1;

    do_op(8'd100, 8'd7, 8'h00, 8'h00, 1'b0, 1'b1);
    check("lit_100_7_q", quotient, 14);
    check("lit_100_7_r", remainder, 2);
    check("lit_100_7_qt", quotient_t, 0);
    check("lit_100_7_busy_t", busy_t, 0);

    do_op(8'd55, 8'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("lit_55_0_q", quotient, 8'hFF);
    check("lit_55_0_r", remainder, 55);
    check("lit_55_0_dz", divByZero, 1);
    check("lit_55_0_dzt", divByZero_t, 0);

    do_op(8'd200, 8'd3, 8'h00, 8'h01, 1'b0, 1'b0);
    check("lit_200_3_q", quotient, 66);
    check("lit_200_3_r", remainder, 2);
    check("lit_200_3_qt", quotient_t, 8'hFF);
    check("lit_200_3_dzt", divByZero_t, 1);
    check("lit_200_3_done_t", quotientDone_t, 0);

    do_op(8'd9, 8'd2, 8'h01, 8'h00, 1'b0, 1'b0);
    check("lit_9_2_q", quotient, 4);
    check("lit_9_2_r", remainder, 1);

    do_op(8'd20, 8'd4, 8'h00, 8'h00, 1'b1, 1'b0);
    check("lit_20_4_q", quotient, 5);
    check("lit_20_4_qt", quotient_t, 8'hFF);
    check("lit_20_4_rt", remainder_t, 8'hFF);
    check("lit_20_4_busy_t", busy_t, 1);

    do_op(8'd100, 8'd7, 8'h00, 8'h00, 1'b0, 1'b0);
    check("lit_sticky_q", quotient, 14);
    check("lit_sticky_qt", quotient_t, 8'hFF);
    check("lit_sticky_busy_t", busy_t, 1);

    // Asynchronous abort in the middle of a calculation.
    begin_op(8'd100, 8'd7, 8'h00, 8'h00, 1'b0);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b0;
    active = 1'b0;
    m_st = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_busy_t", busy_t, 0);
    check("abort_q", quotient, 0);
    check("abort_qt", quotient_t, 0);
    check("abort_r", remainder, 0);
    check("abort_rt", remainder_t, 0);
    check("abort_dzt", divByZero_t, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    do_op(8'd100, 8'd7, 8'h00, 8'h00, 1'b0, 1'b0);
    check("lit_fresh_q", quotient, 14);
    check("lit_fresh_r", remainder, 2);
    check("lit_fresh_qt", quotient_t, 0);
    check("lit_fresh_busy_t", busy_t, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
